// File: rtl/cordic_scheduler_if.sv
// Request/response bundle between the requesting datapath blocks and the
// CORDIC scheduler.
//   master: requesters/consumer side (drives req_valid, req_angle, resp_ready)
//   slave : scheduler side (drives req_ready and the resp_* outputs)
// req_angle packs requester i at bits [i*W +: W]; req_ready is the one-hot grant.
interface cordic_scheduler_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned IDW   = $clog2(N_REQ)
) ();
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_angle;
  logic [N_REQ-1:0]   req_ready;
  logic               resp_valid;
  logic [IDW-1:0]     resp_id;
  logic [W-1:0]       resp_cos;
  logic [W-1:0]       resp_sin;
  logic               resp_ready;

  modport master (
    output req_valid, req_angle, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_cos, resp_sin
  );

  modport slave (
    input  req_valid, req_angle, resp_ready,
    output req_ready, resp_valid, resp_id, resp_cos, resp_sin
  );
endinterface

// File: rtl/cordic_scheduler.sv
// Round-robin scheduler sharing one iterative CORDIC sine/cosine core between
// N_REQ requesters. One angle is accepted at a time, the core is started, the
// fixed core latency is waited out, and cos/sin are captured into a response
// register tagged with the requester index until the consumer accepts it.
// Ports:
//   clock_i      : clock, rising edge
//   reset_i      : synchronous, active-high reset (also resets the core)
//   bus          : request/response bundle (slave side)
//   core_start_o : one-cycle start pulse to the core
//   core_angle_o : angle to the core, held from START through RESP
//   core_cos_i   : core cosine result
//   core_sin_i   : core sine result
//   busy_o       : high whenever an operation is in progress
module cordic_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned W       = 32,
  parameter int unsigned LATENCY = 33
) (
  input  logic              clock_i,
  input  logic              reset_i,
  cordic_scheduler_if.slave bus,
  output logic              core_start_o,
  output logic [W-1:0]      core_angle_o,
  input  logic [W-1:0]      core_cos_i,
  input  logic [W-1:0]      core_sin_i,
  output logic              busy_o
);

  localparam int unsigned IDW  = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(LATENCY);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  rid_q, rid_d;
  logic [W-1:0]    angle_q, angle_d;
  logic [W-1:0]    cos_q, cos_d;
  logic [W-1:0]    sin_q, sin_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            resp_valid_q, resp_valid_d;

  logic            grant_found;
  logic [IDW-1:0]  grant_id;

  // Rotating-priority search: first valid requester at or after ptr_q.
  always_comb begin
    int unsigned j;
    j           = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = 32'(ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!grant_found && bus.req_valid[j[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = j[IDW-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state and datapath next values
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    rid_d        = rid_q;
    angle_d      = angle_q;
    cos_d        = cos_q;
    sin_d        = sin_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    case (state_q)
      StIdle: begin
        if (grant_found) begin
          angle_d = bus.req_angle[grant_id*W +: W];
          id_d    = grant_id;
          ptr_d   = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        cnt_d   = CntW'(LATENCY - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          cos_d        = core_cos_i;
          sin_d        = core_sin_i;
          rid_d        = id_q;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (resp_valid_q && bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ptr_q        <= '0;
      id_q         <= '0;
      rid_q        <= '0;
      angle_q      <= '0;
      cos_q        <= '0;
      sin_q        <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      rid_q        <= rid_d;
      angle_q      <= angle_d;
      cos_q        <= cos_d;
      sin_q        <= sin_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Outputs
  always_comb begin
    core_start_o   = (state_q == StStart);
    busy_o         = (state_q != StIdle);
    core_angle_o   = angle_q;
    bus.resp_valid = resp_valid_q;
    bus.resp_id    = rid_q;
    bus.resp_cos   = cos_q;
    bus.resp_sin   = sin_q;
    bus.req_ready  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      bus.req_ready[i] = (state_q == StIdle) && grant_found && (grant_id == IDW'(i));
    end
  end

endmodule

// File: tb/tb_cordic_scheduler.sv
module tb_cordic_scheduler;
  localparam int unsigned N   = 4;
  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 33;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         core_start;
  logic [W-1:0] core_angle, core_cos, core_sin;
  logic         busy;

  always #5 clk = ~clk;

  cordic_scheduler_if #(.N_REQ(N), .W(W)) bus ();

  cordic_scheduler #(.N_REQ(N), .W(W), .LATENCY(LAT)) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .bus         (bus),
    .core_start_o(core_start),
    .core_angle_o(core_angle),
    .core_cos_i  (core_cos),
    .core_sin_i  (core_sin),
    .busy_o      (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int model_ptr = 0;
  int last_id, last_e0;
  logic [W-1:0] last_cos, last_sin;

  function automatic real to_real(input logic [31:0] a);
    return $itor($signed(a)) / 1073741824.0;
  endfunction

  function automatic logic [31:0] q30(input real x);
    int v;
    v = $rtoi(x * 1073741824.0);
    return v;
  endfunction

  function automatic bit near(input logic [31:0] a, input logic [31:0] b);
    int d;
    d = $signed(a) - $signed(b);
    return (d <= 8) && (d >= -8);
  endfunction

  function automatic logic [31:0] rand_angle();
    logic [31:0] r;
    r = $urandom_range(32'hC90FDAA2, 0);
    return r - 32'h6487ED51;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!rst && core_start) start_cnt <= start_cnt + 1;

  // Behavioural core: junk while computing, exact result LAT cycles after start.
  int ccnt;
  logic [W-1:0] pend_cos, pend_sin;
  always @(posedge clk) begin
    if (rst) begin
      ccnt <= 0; core_cos <= '0; core_sin <= '0;
    end else if (core_start) begin
      ccnt     <= LAT - 1;
      pend_cos <= q30($cos(to_real(core_angle)));
      pend_sin <= q30($sin(to_real(core_angle)));
      core_cos <= $urandom; core_sin <= $urandom;
    end else if (ccnt > 1) begin
      ccnt <= ccnt - 1; core_cos <= $urandom; core_sin <= $urandom;
    end else if (ccnt == 1) begin
      ccnt <= 0; core_cos <= pend_cos; core_sin <= pend_sin;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (model_ptr + k) % N;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_angle(input int i, input logic [W-1:0] a);
    bus.req_angle[i*W +: W] = a;
  endtask

  // Call at a negedge after driving inputs. Returns once the grant is visible.
  task automatic wait_grant(output int g, output logic [W-1:0] ang, output bit ok);
    ok = 0; g = -1; ang = '0;
    for (int t = 0; t < 300; t++) begin
      #1;
      if (|(bus.req_ready & bus.req_valid)) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin check_eq("grant_timeout", 0, 1); return; end
    g = model_grant();
    if (g < 0) begin check_eq("unexpected_grant", bus.req_ready, 0); ok = 0; return; end
    check_eq("grant_onehot", bus.req_ready, 64'(1) << g);
    ang       = bus.req_angle[g*W +: W];
    last_e0   = cyc + 1;
    model_ptr = (g + 1) % N;
  endtask

  task automatic serve(input int stall, input bit pulse0);
    int g, s0, bad;
    bit ok;
    logic [W-1:0] ang, hc, hs;
    logic [1:0] hid;
    bus.resp_ready = (stall == 0);
    wait_grant(g, ang, ok);
    if (!ok) return;
    s0 = start_cnt;
    @(negedge clk);
    bus.req_valid[g] = 1'b0;
    check_eq("start_pulse", core_start, 1);
    check_eq("start_angle", core_angle, ang);
    check_eq("start_busy", busy, 1);
    check_eq("start_no_ready", bus.req_ready, 0);
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.resp_valid) begin ok = 1; break; end
    end
    check_eq("resp_seen", ok, 1);
    if (!ok) return;
    check_eq("latency", cyc - last_e0, LAT + 1);
    check_eq("resp_id", bus.resp_id, g);
    check_eq("resp_cos", bus.resp_cos, q30($cos(to_real(ang))));
    check_eq("resp_sin", bus.resp_sin, q30($sin(to_real(ang))));
    check_eq("one_start", start_cnt - s0, 1);
    last_id = g; last_cos = bus.resp_cos; last_sin = bus.resp_sin;
    if (stall > 0) begin
      hid = bus.resp_id; hc = bus.resp_cos; hs = bus.resp_sin; bad = 0;
      for (int t = 0; t < stall; t++) begin
        if (pulse0) bus.req_valid[0] = (t >= 2 && t < 6);
        @(negedge clk);
        if (!bus.resp_valid || bus.resp_id != hid || bus.resp_cos != hc ||
            bus.resp_sin != hs || bus.req_ready != 0 || core_start || !busy) bad++;
      end
      check_eq("stall_stable", bad, 0);
      check_eq("stall_no_start", start_cnt - s0, 1);
      if (pulse0) bus.req_valid[0] = 1'b0;
      bus.resp_ready = 1'b1;
    end
    @(negedge clk);
    check_eq("resp_cleared", bus.resp_valid, 0);
    check_eq("idle_after_resp", busy, 0);
  endtask

  initial begin
    int g, prev_e0, s0, bad, exp_first;
    bit ok;
    logic [W-1:0] ang;

    bus.req_valid = '0; bus.req_angle = '0; bus.resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_resp_valid", bus.resp_valid, 0);
    check_eq("rst_resp_id", bus.resp_id, 0);
    check_eq("rst_resp_cos", bus.resp_cos, 0);
    check_eq("rst_resp_sin", bus.resp_sin, 0);
    check_eq("rst_core_start", core_start, 0);
    check_eq("rst_core_angle", core_angle, 0);
    check_eq("rst_req_ready", bus.req_ready, 0);

    // Single request from requester 2, angle 0
    set_angle(2, 32'h0);
    bus.req_valid = 4'b0100;
    #1 check_eq("idle_grant_comb", bus.req_ready, 4'b0100);
    serve(0, 0);
    check_eq("zero_cos_tol", near(last_cos, 32'h40000000), 1);
    check_eq("zero_sin_tol", near(last_sin, 32'h0), 1);

    // Backpressure with a withdrawn pulse from requester 0 during RESP
    set_angle(1, rand_angle());
    bus.req_valid = 4'b0010;
    serve(100, 1);
    s0 = start_cnt; bad = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (busy || bus.resp_valid || bus.req_ready != 0) bad++;
    end
    check_eq("withdrawn_ignored", bad, 0);
    check_eq("withdrawn_no_start", start_cnt - s0, 0);

    // Reset in WAIT
    set_angle(1, rand_angle());
    bus.req_valid = 4'b0010;
    wait_grant(g, ang, ok);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    check_eq("wrst_busy", busy, 0);
    check_eq("wrst_resp_valid", bus.resp_valid, 0);
    check_eq("wrst_core_start", core_start, 0);
    check_eq("wrst_core_angle", core_angle, 0);
    check_eq("wrst_resp_cos", bus.resp_cos, 0);
    bad = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus.resp_valid || busy) bad++;
    end
    check_eq("wrst_no_resp", bad, 0);
    set_angle(0, rand_angle()); set_angle(3, rand_angle());
    bus.req_valid = 4'b1001;
    serve(0, 0);
    check_eq("ptr_restart", last_id, 0);
    bus.req_valid = '0;

    // Fairness from a fresh pointer
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < N; i++) set_angle(i, rand_angle());
    bus.req_valid = 4'b1111;
    prev_e0 = 0;
    for (int op = 0; op < 8; op++) begin
      serve(0, 0);
      check_eq("fair_order", last_id, op % 4);
      if (op > 0) check_eq("fair_period", last_e0 - prev_e0, LAT + 3);
      prev_e0 = last_e0;
      set_angle(last_id, rand_angle());
      bus.req_valid[last_id] = 1'b1;
    end
    bus.req_valid = '0;

    // pi/4 from requester 3 against -pi/4 from requester 1
    set_angle(3, 32'h3243F6A9);
    set_angle(1, 32'hCDBC0957);
    bus.req_valid = 4'b1010;
    exp_first = (model_ptr <= 1) ? 1 : 3;
    for (int k = 0; k < 2; k++) begin
      serve(0, 0);
      if (k == 0) check_eq("pi4_first", last_id, exp_first);
      check_eq("pi4_cos_tol", near(last_cos, 32'h2D413CCD), 1);
      if (last_id == 3) check_eq("pi4_sin_tol", near(last_sin, 32'h2D413CCD), 1);
      else              check_eq("mpi4_sin_tol", near(last_sin, 32'hD2BEC333), 1);
    end
    bus.req_valid = '0;

    // Randomized traffic
    for (int op = 0; op < 20; op++) begin
      for (int i = 0; i < N; i++) set_angle(i, rand_angle());
      bus.req_valid = 4'($urandom_range(15, 1));
      serve($urandom_range(4, 0), 0);
    end
    bus.req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
